// File: rtl/morse_tx_fifo_if.sv
// Character handshake between a producer and the Morse transmitter queue.
//   char_in    : 6-bit character code (0 space, 1-26 A-Z, 27-36 digits 0-9)
//   char_valid : producer offers char_in this cycle
//   char_ready : queue can accept a character this cycle
// A transfer happens on a rising edge where char_valid && char_ready.
interface morse_tx_fifo_if;
   logic [5:0] char_in;
   logic       char_valid;
   logic       char_ready;

   modport master (output char_in, output char_valid, input char_ready);
   modport slave  (input char_in, input char_valid, output char_ready);
endinterface

// File: rtl/morse_tx_fifo.sv
// Queued International Morse transmitter.
// Characters are pushed through the chr handshake into a FIFO, then keyed
// out one at a time on morse_out with standard dot/dash/gap timing.
//   clk         : single clock, rising edge
//   rst_n       : synchronous active-low reset
//   chr         : character handshake (slave side)
//   speed       : unit length = max(1, UNIT_CYCLES >> speed), sampled per character
//   abort       : flush the queue and silence the output at the next edge
//   morse_out   : keyed output, high = tone
//   busy        : character in progress or queue non-empty
//   cur_char    : code being sent, 0 when idle
//   fifo_count  : number of queued characters
//   err_invalid : one-cycle pulse after an invalid code is popped
//
// state      | meaning
// -----------+-----------------------------------------------------------
// S_IDLE     | nothing in progress; leaves as soon as the queue is non-empty
// S_LOAD     | pop head, latch code, unit length and symbol pattern
// S_MARK     | tone on for one dot (1 unit) or dash (3 units)
// S_SYM_GAP  | 1 unit silence between symbols of one character
// S_CHAR_GAP | 3 unit silence after the last symbol of a character
// S_WORD_GAP | 7 unit silence for a space character
module morse_tx_fifo #(
   parameter int UNIT_CYCLES = 250000,
   parameter int FIFO_DEPTH  = 8,
   parameter int TIMER_W     = 25
) (
   input  logic                          clk,
   input  logic                          rst_n,
   morse_tx_fifo_if.slave                chr,
   input  logic [1:0]                    speed,
   input  logic                          abort,
   output logic                          morse_out,
   output logic                          busy,
   output logic [5:0]                    cur_char,
   output logic [$clog2(FIFO_DEPTH):0]   fifo_count,
   output logic                          err_invalid
);

   localparam int AW = $clog2(FIFO_DEPTH);
   localparam int CW = AW + 1;
   localparam logic [TIMER_W-1:0] UNIT_BASE = TIMER_W'(UNIT_CYCLES);
   localparam logic [TIMER_W-1:0] ONE_T     = TIMER_W'(1);

   typedef enum logic [2:0] {
      S_IDLE, S_LOAD, S_MARK, S_SYM_GAP, S_CHAR_GAP, S_WORD_GAP
   } state_t;

   state_t              state_q, state_d;
   logic [5:0]          mem [FIFO_DEPTH];
   logic [AW-1:0]       wr_ptr_q, wr_ptr_d, rd_ptr_q, rd_ptr_d;
   logic [CW-1:0]       count_q, count_d;
   logic [TIMER_W-1:0]  timer_q, timer_d;
   logic [TIMER_W-1:0]  unit_q, unit_d;
   logic [4:0]          sym_q, sym_d;
   logic [2:0]          nsym_q, nsym_d;
   logic [5:0]          cur_q, cur_d;
   logic                err_q, err_d;

   logic                ready;
   logic                push;
   logic                pop;
   logic [5:0]          head;
   logic [7:0]          lut;
   logic [4:0]          sym_left;
   logic [TIMER_W-1:0]  unit_shift, unit_new, unit_use;
   logic [TIMER_W-1:0]  dot_t, dash_t, gap3_t, gap7_t;

   // {length[2:0], pattern[4:0]}: pattern right-aligned, first symbol in the
   // most significant used bit, 1 = dash.
   function automatic logic [7:0] morse_lut(input logic [5:0] c);
      case (c)
         6'd1:  morse_lut = {3'd2, 5'b00001};  // A .-
         6'd2:  morse_lut = {3'd4, 5'b01000};  // B -...
         6'd3:  morse_lut = {3'd4, 5'b01010};  // C -.-.
         6'd4:  morse_lut = {3'd3, 5'b00100};  // D -..
         6'd5:  morse_lut = {3'd1, 5'b00000};  // E .
         6'd6:  morse_lut = {3'd4, 5'b00010};  // F ..-.
         6'd7:  morse_lut = {3'd3, 5'b00110};  // G --.
         6'd8:  morse_lut = {3'd4, 5'b00000};  // H ....
         6'd9:  morse_lut = {3'd2, 5'b00000};  // I ..
         6'd10: morse_lut = {3'd4, 5'b00111};  // J .---
         6'd11: morse_lut = {3'd3, 5'b00101};  // K -.-
         6'd12: morse_lut = {3'd4, 5'b00100};  // L .-..
         6'd13: morse_lut = {3'd2, 5'b00011};  // M --
         6'd14: morse_lut = {3'd2, 5'b00010};  // N -.
         6'd15: morse_lut = {3'd3, 5'b00111};  // O ---
         6'd16: morse_lut = {3'd4, 5'b00110};  // P .--.
         6'd17: morse_lut = {3'd4, 5'b01101};  // Q --.-
         6'd18: morse_lut = {3'd3, 5'b00010};  // R .-.
         6'd19: morse_lut = {3'd3, 5'b00000};  // S ...
         6'd20: morse_lut = {3'd1, 5'b00001};  // T -
         6'd21: morse_lut = {3'd3, 5'b00001};  // U ..-
         6'd22: morse_lut = {3'd4, 5'b00001};  // V ...-
         6'd23: morse_lut = {3'd3, 5'b00011};  // W .--
         6'd24: morse_lut = {3'd4, 5'b01001};  // X -..-
         6'd25: morse_lut = {3'd4, 5'b01011};  // Y -.--
         6'd26: morse_lut = {3'd4, 5'b01100};  // Z --..
         6'd27: morse_lut = {3'd5, 5'b11111};  // 0
         6'd28: morse_lut = {3'd5, 5'b01111};  // 1
         6'd29: morse_lut = {3'd5, 5'b00111};  // 2
         6'd30: morse_lut = {3'd5, 5'b00011};  // 3
         6'd31: morse_lut = {3'd5, 5'b00001};  // 4
         6'd32: morse_lut = {3'd5, 5'b00000};  // 5
         6'd33: morse_lut = {3'd5, 5'b10000};  // 6
         6'd34: morse_lut = {3'd5, 5'b11000};  // 7
         6'd35: morse_lut = {3'd5, 5'b11100};  // 8
         6'd36: morse_lut = {3'd5, 5'b11110};  // 9
         default: morse_lut = 8'd0;
      endcase
   endfunction

   assign ready          = (count_q != CW'(FIFO_DEPTH));
   assign push           = rst_n && chr.char_valid && ready && !abort;
   assign chr.char_ready = ready;

   assign head     = mem[rd_ptr_q];
   assign lut      = morse_lut(head);
   // Shift so the first symbol always sits in bit 4.
   assign sym_left = lut[4:0] << (3'd5 - lut[7:5]);

   assign unit_shift = UNIT_BASE >> speed;
   assign unit_new   = (unit_shift == '0) ? ONE_T : unit_shift;
   // In LOAD the unit register is not yet written, so durations chosen on
   // that cycle must come from the freshly computed value.
   assign unit_use   = (state_q == S_LOAD) ? unit_new : unit_q;

   // Timer counts down to zero inclusive, so it is loaded with duration-1.
   assign dot_t  = unit_use - ONE_T;
   assign dash_t = (unit_use << 1) + unit_use - ONE_T;
   assign gap3_t = dash_t;
   assign gap7_t = (unit_use << 3) - unit_use - ONE_T;

   always_ff @(posedge clk) begin
      if (!rst_n) begin
         state_q  <= S_IDLE;
         wr_ptr_q <= '0;
         rd_ptr_q <= '0;
         count_q  <= '0;
         timer_q  <= '0;
         unit_q   <= ONE_T;
         sym_q    <= '0;
         nsym_q   <= '0;
         cur_q    <= '0;
         err_q    <= 1'b0;
      end else begin
         state_q  <= state_d;
         wr_ptr_q <= wr_ptr_d;
         rd_ptr_q <= rd_ptr_d;
         count_q  <= count_d;
         timer_q  <= timer_d;
         unit_q   <= unit_d;
         sym_q    <= sym_d;
         nsym_q   <= nsym_d;
         cur_q    <= cur_d;
         err_q    <= err_d;
      end
   end

   always_ff @(posedge clk) begin
      if (push) mem[wr_ptr_q] <= chr.char_in;
   end

   always_comb begin
      state_d = state_q;
      timer_d = timer_q;
      unit_d  = unit_q;
      sym_d   = sym_q;
      nsym_d  = nsym_q;
      cur_d   = cur_q;
      err_d   = 1'b0;
      pop     = 1'b0;
      case (state_q)
         S_IDLE: begin
            if (count_q != '0) state_d = S_LOAD;
         end
         S_LOAD: begin
            pop    = 1'b1;
            unit_d = unit_new;
            sym_d  = sym_left;
            nsym_d = lut[7:5];
            if (head == 6'd0) begin
               state_d = S_WORD_GAP;
               timer_d = gap7_t;
            end else if (head > 6'd36) begin
               state_d = S_IDLE;
               err_d   = 1'b1;
            end else begin
               state_d = S_MARK;
               cur_d   = head;
               timer_d = sym_left[4] ? dash_t : dot_t;
            end
         end
         S_MARK: begin
            if (timer_q == '0) begin
               if (nsym_q > 3'd1) begin
                  state_d = S_SYM_GAP;
                  timer_d = dot_t;
                  sym_d   = sym_q << 1;
                  nsym_d  = nsym_q - 3'd1;
               end else begin
                  state_d = S_CHAR_GAP;
                  timer_d = gap3_t;
               end
            end else begin
               timer_d = timer_q - ONE_T;
            end
         end
         S_SYM_GAP: begin
            if (timer_q == '0) begin
               state_d = S_MARK;
               timer_d = sym_q[4] ? dash_t : dot_t;
            end else begin
               timer_d = timer_q - ONE_T;
            end
         end
         S_CHAR_GAP, S_WORD_GAP: begin
            if (timer_q == '0) state_d = S_IDLE;
            else               timer_d = timer_q - ONE_T;
         end
         default: state_d = S_IDLE;
      endcase
      if (state_d == S_IDLE) cur_d = '0;
      if (abort) begin
         state_d = S_IDLE;
         timer_d = '0;
         cur_d   = '0;
         err_d   = 1'b0;
         pop     = 1'b0;
      end
   end

   always_comb begin
      wr_ptr_d = push ? wr_ptr_q + 1'b1 : wr_ptr_q;
      rd_ptr_d = pop  ? rd_ptr_q + 1'b1 : rd_ptr_q;
      case ({push, pop})
         2'b10:   count_d = count_q + 1'b1;
         2'b01:   count_d = count_q - 1'b1;
         default: count_d = count_q;
      endcase
      if (abort) begin
         wr_ptr_d = '0;
         rd_ptr_d = '0;
         count_d  = '0;
      end
   end

   always_comb begin
      morse_out   = (state_q == S_MARK);
      busy        = (state_q != S_IDLE) || (count_q != '0);
      cur_char    = cur_q;
      fifo_count  = count_q;
      err_invalid = err_q;
   end

endmodule

// File: doc/morse_tx_fifo.md
MORSE_TX_FIFO -- requirements
Module: morse_tx_fifo

Interface
REQ-001 SHALL have parameter UNIT_CYCLES, default 250000: clock cycles per Morse time unit at speed 0; minimum 1.
REQ-002 SHALL have parameter FIFO_DEPTH, default 8: character queue depth; power of two, minimum 2.
REQ-003 SHALL have parameter TIMER_W, default 25: timer width; must hold 7*UNIT_CYCLES.
REQ-004 SHALL have port clk  in  1  the single clock; all logic on its rising edge.
REQ-005 SHALL have port rst_n  in  1  reset, synchronous and active-low.
REQ-006 SHALL have port char_in  in  6  character code: 0 space, 1-26 A-Z, 27-36 digits 0-9, 37-63 invalid.
REQ-007 SHALL have port char_valid  in  1  char_in offered this cycle.
REQ-008 SHALL have port char_ready  out  1  queue can accept a character.
REQ-009 SHALL have port speed  in  2  unit-length divider select.
REQ-010 SHALL have port abort  in  1  flush the queue and stop output.
REQ-011 SHALL have port morse_out  out  1  keyed serial Morse; high = tone.
REQ-012 SHALL have port busy  out  1  queue non-empty or character in progress.
REQ-013 SHALL have port cur_char  out  6  code of the character being sent; 0 when idle.
REQ-014 SHALL have port fifo_count  out  $clog2(FIFO_DEPTH)+1  queued characters.
REQ-015 SHALL have port err_invalid  out  1  one-cycle pulse when an invalid code is popped.

Function
REQ-016 SHALL push char_in when char_valid && char_ready; char_ready = (fifo_count < FIFO_DEPTH), a registered count; a pop in the same cycle does not make a full queue ready.
REQ-017 SHALL update fifo_count by +1 on push, -1 on pop, unchanged on simultaneous push and pop; pointers wrap modulo FIFO_DEPTH.
REQ-018 SHALL implement FSM states IDLE, LOAD, MARK, SYM_GAP, CHAR_GAP, WORD_GAP.
REQ-019 SHALL go IDLE->LOAD when fifo_count>0; LOAD pops one entry, latches code into cur_char, and latches unit = max(1, UNIT_CYCLES >> speed); speed changes mid-character have no effect.
REQ-020 SHALL encode International Morse (A-Z, 0-9); each character has 1-5 symbols held MSB-first with 1 = dash; digits use 5 symbols.
REQ-021 SHALL go LOAD->MARK for a valid letter/digit; morse_out high for exactly 1*unit cycles (dot) or 3*unit (dash), starting the cycle after LOAD.
REQ-022 SHALL go MARK->SYM_GAP (morse_out low 1*unit) if symbols remain, then MARK for the next symbol; after the last symbol go to CHAR_GAP (low 3*unit), then IDLE.
REQ-023 SHALL go LOAD->WORD_GAP for code 0: morse_out low 7*unit cycles, then IDLE.
REQ-024 SHALL, for codes 37-63, pulse err_invalid for the cycle after LOAD, emit nothing, return to IDLE.
REQ-025 SHALL hold busy = (state != IDLE) || (fifo_count != 0); cur_char = 0 in IDLE.
REQ-026 SHALL, when abort is high, at the next edge empty the queue, enter IDLE and drive morse_out low; abort overrides a simultaneous push (push dropped).
REQ-027 SHALL keep morse_out low in every state other than MARK.

Reset
REQ-028 SHALL, on a clock edge with rst_n low, set state IDLE, fifo_count 0, pointers 0, morse_out 0, busy 0, cur_char 0, err_invalid 0, char_ready 1, timer 0; applies mid-character identically.
REQ-029 SHALL not accept a push on a cycle where rst_n is low.

Verification (UNIT_CYCLES=4, FIFO_DEPTH=8 unless stated)
REQ-030 SHALL verify: push 'E'(5), speed 0 -> morse_out high 4 cycles, low 12, busy drops after CHAR_GAP, cur_char 5 during send.
REQ-031 SHALL verify: push 'A'(1) then '0'(27) -> high4 low4 high12 low12, then five 12-cycle marks separated by 4-cycle gaps, then low 12.
REQ-032 SHALL verify: push space(0), speed 2 -> unit 1, morse_out low 7 cycles with busy high, then idle.
REQ-033 SHALL verify: 9 back-to-back pushes while sending -> 8 accepted, char_ready low, 9th ignored; output order matches push order.
REQ-034 SHALL verify: push 40 -> err_invalid one-cycle pulse, no morse_out activity; abort mid-dash -> morse_out 0 and fifo_count 0 next cycle.
REQ-035 SHALL verify: rst_n low mid-MARK -> all outputs at reset values next edge; first push after release transmits normally.
